// File: rtl/ae350_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// ae350_reset_sequencer_if
//
// Purpose : bundles the board-facing signals of the AE350 reset sequencer so
//           the sequencer and its environment share one typed connection.
//
// Signals :
//   lock_in      [NUM_LOCKS-1:0]   PLL lock flags (asynchronous to clk)
//   init_done                      DDR3 initialisation complete (asynchronous)
//   ext_rstn                       push-button reset, active-low, bouncy
//   rst_n_out    [NUM_DOMAINS-1:0] per-domain active-low resets, bit 0 first
//   seq_done                       high while the sequencer is in RUN
//   init_timeout                   sticky DDR3 init watchdog flag
//   state_o      [2:0]             current sequencer state (debug)
//
// Modports:
//   master : board / environment side, drives the raw inputs
//   slave  : sequencer side, drives the reset outputs and state
// ---------------------------------------------------------------------------
interface ae350_reset_sequencer_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int NUM_LOCKS   = 2
);
    logic [NUM_LOCKS-1:0]   lock_in;
    logic                   init_done;
    logic                   ext_rstn;
    logic [NUM_DOMAINS-1:0] rst_n_out;
    logic                   seq_done;
    logic                   init_timeout;
    logic [2:0]             state_o;

    modport master (
        output lock_in, init_done, ext_rstn,
        input  rst_n_out, seq_done, init_timeout, state_o
    );

    modport slave (
        input  lock_in, init_done, ext_rstn,
        output rst_n_out, seq_done, init_timeout, state_o
    );
endinterface

// File: rtl/ae350_reset_sequencer.sv
// ---------------------------------------------------------------------------
// ae350_reset_sequencer
//
// Purpose : ordered multi-domain reset release for the AE350 SoC. Domains are
//           released one at a time, STAGE_GAP cycles apart, once every PLL is
//           locked, DDR3 init is done and the push button is released. Any
//           lock loss, init loss or button press re-asserts every domain.
//
// Ports   :
//   clk  : sequencer clock (board 50 MHz)
//   rst  : synchronous active-high reset
//   bus  : ae350_reset_sequencer_if.slave
//          (lock_in, init_done, ext_rstn in; rst_n_out, seq_done,
//           init_timeout, state_o out)
//
// Optional feature:
//   RSTSEQ_INIT_TIMEOUT_EN - when defined, a watchdog counts cycles spent in
//   WAIT_INIT; at TIMEOUT_CYCLES-1 the FSM enters FAULT and sets the sticky
//   init_timeout flag. When undefined, WAIT_INIT waits indefinitely and
//   init_timeout is tied low.
// ---------------------------------------------------------------------------
module ae350_reset_sequencer #(
    parameter int NUM_DOMAINS     = 4,
    parameter int NUM_LOCKS       = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int STAGE_GAP       = 16,
    parameter int TIMEOUT_CYCLES  = 1048576
) (
    input  logic                     clk,
    input  logic                     rst,
    ae350_reset_sequencer_if.slave   bus
);

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_WAIT_INIT = 3'd2;
    localparam logic [2:0] S_RELEASE   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    // Counter widths; clamp to 1 bit so a limit of 1 still gives a legal vector.
    localparam int DB_W  = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam int GAP_W = ($clog2(STAGE_GAP) < 1) ? 1 : $clog2(STAGE_GAP);
    localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOMAINS - 1);

    // ---------------- 2-FF synchronisers ----------------
    logic [NUM_LOCKS-1:0] r_lock_meta, r_lock_sync;
    logic                 r_init_meta, r_init_sync;
    logic                 r_btn_meta,  r_btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_meta <= '0;
            r_lock_sync <= '0;
            r_init_meta <= 1'b0;
            r_init_sync <= 1'b0;
            // Button idles high, so its synchroniser starts released.
            r_btn_meta  <= 1'b1;
            r_btn_sync  <= 1'b1;
        end else begin
            r_lock_meta <= bus.lock_in;
            r_lock_sync <= r_lock_meta;
            r_init_meta <= bus.init_done;
            r_init_sync <= r_init_meta;
            r_btn_meta  <= bus.ext_rstn;
            r_btn_sync  <= r_btn_meta;
        end
    end

    // ---------------- button debouncer ----------------
    logic            r_btn_stable;
    logic [DB_W-1:0] r_db_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_stable <= 1'b1;
            r_db_cnt     <= '0;
        end else if (r_btn_sync != r_btn_stable) begin
            if (r_db_cnt == DB_MAX) begin
                r_btn_stable <= r_btn_sync;
                r_db_cnt     <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    logic w_pressed, w_locks_ok, w_init_ok;
    assign w_pressed  = ~r_btn_stable;
    assign w_locks_ok = &r_lock_sync;
    assign w_init_ok  = r_init_sync;

    // ---------------- sequencer FSM ----------------
    logic [2:0]             r_state;
    logic [NUM_DOMAINS-1:0] r_rst_n;
    logic                   r_seq_done;
    logic [GAP_W-1:0]       r_gap;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_DOMAINS-1:0] w_rel_mask;

`ifdef RSTSEQ_INIT_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] r_wd;
    logic            r_timeout;
`else
    // Watchdog limit has no effect in this build.
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // One-hot of the domain being released; compared per bit so the index
    // never needs to be narrower or wider than the reset vector.
    always_comb begin
        w_rel_mask = '0;
        for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (IDX_W'(k) == r_idx) w_rel_mask[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HOLD;
            r_rst_n    <= '0;
            r_seq_done <= 1'b0;
            r_gap      <= '0;
            r_idx      <= '0;
`ifdef RSTSEQ_INIT_TIMEOUT_EN
            r_wd       <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef RSTSEQ_INIT_TIMEOUT_EN
            // Watchdog only runs while in WAIT_INIT; restarts on every entry.
            r_wd <= '0;
`endif
            case (r_state)
                S_HOLD: begin
                    r_rst_n    <= '0;
                    r_seq_done <= 1'b0;
                    if (!w_pressed) r_state <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (w_pressed)       r_state <= S_HOLD;
                    else if (w_locks_ok) r_state <= S_WAIT_INIT;
                end
                S_WAIT_INIT: begin
                    if (w_pressed || !w_locks_ok) begin
                        r_state <= S_HOLD;
                    end else if (w_init_ok) begin
                        r_state <= S_RELEASE;
                        r_gap   <= '0;
                        r_idx   <= '0;
                    end
`ifdef RSTSEQ_INIT_TIMEOUT_EN
                    else if (r_wd == WD_MAX) begin
                        r_state   <= S_FAULT;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
`endif
                end
                S_RELEASE: begin
                    // Abort wins over a release scheduled for this same edge.
                    if (w_pressed || !w_locks_ok || !w_init_ok) begin
                        r_state <= S_HOLD;
                        r_rst_n <= '0;
                    end else if (r_gap == GAP_MAX) begin
                        r_rst_n <= r_rst_n | w_rel_mask;
                        r_idx   <= r_idx + IDX_W'(1);
                        r_gap   <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state    <= S_RUN;
                            r_seq_done <= 1'b1;
                        end
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_pressed || !w_locks_ok || !w_init_ok) begin
                        r_state    <= S_HOLD;
                        r_rst_n    <= '0;
                        r_seq_done <= 1'b0;
                    end else begin
                        r_rst_n    <= '1;
                        r_seq_done <= 1'b1;
                    end
                end
                S_FAULT: begin
                    r_rst_n <= '0;
                    if (w_pressed) begin
                        r_state <= S_HOLD;
`ifdef RSTSEQ_INIT_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state    <= S_HOLD;
                    r_rst_n    <= '0;
                    r_seq_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_n_out = r_rst_n;
    assign bus.seq_done  = r_seq_done;
    assign bus.state_o   = r_state;
`ifdef RSTSEQ_INIT_TIMEOUT_EN
    assign bus.init_timeout = r_timeout;
`else
    assign bus.init_timeout = 1'b0;
`endif

endmodule
